// File: rtl/relu_if.sv
// relu_if: stream-side signals of the stochastic ReLU array
interface relu_if #(parameter int CH = 4);
   logic          en;
   logic          clr;
   logic          leak_mode;
   logic [CH-1:0] in;
   logic [CH-1:0] leak_rng;
   logic [CH-1:0] out;
   logic          out_valid;
   logic [CH-1:0] pos;
   modport master (output en, clr, leak_mode, in, leak_rng, input out, out_valid, pos);
   modport slave  (input en, clr, leak_mode, in, leak_rng, output out, out_valid, pos);
endinterface

// File: rtl/relu_array.sv
// relu_array: per-channel saturating up/down counters gating stochastic bitstreams into (leaky) ReLU outputs
module relu_array #(
   parameter int CH    = 4,
   parameter int DEPTH = 5
) (
   input logic   clk,
   input logic   rst,
   relu_if.slave b
);
   localparam logic [DEPTH:0] MID = {1'b1, {DEPTH{1'b0}}};
   localparam logic [DEPTH:0] MAX = '1;
   logic [DEPTH:0] cnt [CH];
   logic [CH-1:0]  out_r;
   logic           ov;
   always_ff @(posedge clk) begin
      if (rst || b.clr) begin
         for (int i = 0; i < CH; i++) cnt[i] <= MID;
         out_r <= '0;
         ov    <= 1'b0;
      end else begin
         ov <= b.en;
         for (int i = 0; i < CH; i++) begin
            out_r[i] <= b.en & (cnt[i][DEPTH] ? b.in[i] : b.leak_mode & b.in[i] & b.leak_rng[i]);
            if (b.en && b.in[i] && cnt[i] != MAX) cnt[i] <= cnt[i] + 1'b1;
            else if (b.en && !b.in[i] && cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
         end
      end
   end
   for (genvar g = 0; g < CH; g++) begin : g_pos
      assign b.pos[g] = cnt[g][DEPTH];
   end
   assign b.out       = out_r;
   assign b.out_valid = ov;
endmodule

// File: doc/relu_array.md
RELU_ARRAY -- requirements
Module: relu_array

Interface
REQ-001 Parameter CH, default 4: number of independent stochastic ReLU channels, legal range 1..64.
REQ-002 Parameter DEPTH, default 5: each channel counter is DEPTH+1 bits wide; legal range 2..15.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  input valid: when 1, the in bits this cycle are consumed.
REQ-006 clr  input  1  synchronous counter re-centre, independent of rst.
REQ-007 leak_mode  input  1  0 = plain ReLU; 1 = leaky ReLU.
REQ-008 in  input  CH  one unipolar stochastic bitstream bit per channel.
REQ-009 leak_rng  input  CH  per-channel leak-scaling random bit, used only when leak_mode=1.
REQ-010 out  output  CH  registered ReLU output bitstream.
REQ-011 out_valid  output  1  registered; marks cycles where out carries a result.
REQ-012 pos  output  CH  per-channel sign flag, driven directly from counter state.

Function
REQ-013 Each channel shall hold a counter cnt[i] of DEPTH+1 bits, with MID = 2^DEPTH and MAX = 2^(DEPTH+1)-1.
REQ-014 pos[i] shall equal cnt[i] bit DEPTH, i.e. 1 iff cnt[i] >= MID.
REQ-015 On a cycle with en=1 and clr=0, out[i] shall load in[i] if pos[i]=1 before the edge.
REQ-016 In that case, if pos[i]=0 before the edge, out[i] shall load (leak_mode & in[i] & leak_rng[i]).
REQ-017 In that case, out_valid shall load 1, giving a latency of one clock from in to out.
REQ-018 On that cycle, cnt[i] shall increment if in[i]=1 and cnt[i]<MAX, and shall decrement if in[i]=0 and cnt[i]>0.
REQ-019 cnt[i] shall otherwise hold: saturate at MAX and at 0, with no wrap-around in either direction.
REQ-020 On a cycle with en=0 and clr=0, all counters shall hold, out shall load 0 and out_valid shall load 0.
REQ-021 clr=1 shall set every cnt[i] to MID, out to 0 and out_valid to 0.
REQ-022 clr takes priority over en: input on a clr cycle is discarded and does not move the counters.
REQ-023 All channels shall update in parallel and independently; channel i's state shall depend only on in[i] and leak_rng[i].
REQ-024 leak_mode and leak_rng shall be sampled on the same edge as in; changing leak_mode mid-stream shall not alter counter state.
REQ-025 The block shall have no combinational path from any input to out, out_valid or pos.

Reset
REQ-026 rst=1 shall set every cnt[i] to MID, so pos is all ones after reset.
REQ-027 rst=1 shall set out to 0 and out_valid to 0.
REQ-028 rst shall override en and clr, and asserting rst mid-stream shall discard all in-flight state in one cycle.

Verification
REQ-029 All scenarios use CH=4, DEPTH=5, so MID=32 and MAX=63.
REQ-030 Reset release: rst held 2 cycles, then en=0 -> out=0, out_valid=0, pos=4'b1111, every cnt=32.
REQ-031 Sign flip: en=1, leak_mode=0, in[0]=0 for 1 cycle -> next cycle out[0]=0, cnt[0]=31, pos[0]=0.
REQ-032 Sign flip, continued: then in[0]=1 for 1 cycle -> out[0]=0 (suppressed), cnt[0]=32, pos[0]=1.
REQ-033 Saturation: in=4'b1111 for 40 cycles -> cnt=63 for all channels and out=4'b1111 throughout.
REQ-034 Saturation, continued: then in=0 for 32 cycles -> cnt=31 and pos=0.
REQ-035 Underflow: in=0 for 40 cycles from reset -> cnt=0 with no wrap to 63; then one in=1 -> cnt=1, pos=0.
REQ-036 Leaky: with pos[2]=0, leak_mode=1 and in[2]=1, leak_rng[2]=1 -> out[2]=1, while leak_rng[2]=0 -> out[2]=0; the same stimulus with leak_mode=0 -> out[2]=0.
REQ-037 Hold/clear: en=0 for 10 cycles -> counters unchanged and out_valid=0.
REQ-038 Hold/clear, continued: clr=1 together with en=1 and in=4'b1111 -> cnt=32 everywhere, out=0, out_valid=0; rst mid-stream gives the same result.
